// File: rtl/octal_bus_fifo_pkg.sv
// Shared constants and width helpers for the octal bus FIFO.
// Imported by octal_bus_fifo and octal_bus_fifo_mem.
package octal_bus_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Pointer width never drops below one bit so DEPTH=2 still has a usable index.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [cnt_w(DEF_DEPTH)-1:0] count_t;

endpackage

// File: rtl/octal_bus_fifo_mem.sv
// Storage array for the octal bus FIFO: one synchronous write port,
// one asynchronous read port, whole array cleared by CLR_N.
module octal_bus_fifo_mem
    import octal_bus_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEF_DEPTH)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/octal_bus_fifo.sv
// First-word-fall-through byte FIFO feeding the octal register stage.
// OCTAL_BUS_FIFO_TRISTATE_EN: when defined, O floats while OENB_N=1.
module octal_bus_fifo
    import octal_bus_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    input  logic [WIDTH-1:0]          I,
    input  logic                      WR,
    input  logic                      RD,
    input  logic                      OENB_N,
    output logic [WIDTH-1:0]          O,
    output logic                      IR,
    output logic                      OR,
    output logic [cnt_w(DEPTH)-1:0]   COUNT,
    output logic                      OVF
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             ir;
    logic             orr;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] head;

    // Flags come only from the registered count, so WR/RD never reach them combinationally.
    assign ir    = (count != CW'(DEPTH));
    assign orr   = (count != '0);
    assign wr_ok = WR & ir;
    assign rd_ok = RD & orr;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (WR && !ir) begin
                ovf <= 1'b1;
            end
        end
    end

    octal_bus_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (I),
        .raddr (rptr),
        .rdata (head)
    );

`ifdef OCTAL_BUS_FIFO_TRISTATE_EN
    assign O = OENB_N ? {WIDTH{1'bz}} : head;
`else
    logic unused_oenb;
    assign unused_oenb = OENB_N;
    assign O = head;
`endif

    assign IR    = ir;
    assign OR    = orr;
    assign COUNT = count;
    assign OVF   = ovf;

endmodule

// File: tb/tb_octal_bus_fifo.sv
// Directed self-checking bench for octal_bus_fifo (WIDTH=8, DEPTH=4).
module tb_octal_bus_fifo;

    logic       CLK;
    logic       CLR_N;
    logic [7:0] I;
    logic       WR;
    logic       RD;
    logic       OENB_N;
    logic [7:0] O;
    logic       IR;
    logic       OR;
    logic [2:0] COUNT;
    logic       OVF;

    int n_assert = 0;
    int n_fail   = 0;

    octal_bus_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .I      (I),
        .WR     (WR),
        .RD     (RD),
        .OENB_N (OENB_N),
        .O      (O),
        .IR     (IR),
        .OR     (OR),
        .COUNT  (COUNT),
        .OVF    (OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_state(input string tag, input logic [7:0] o_e, input logic [2:0] c_e,
                             input logic ir_e, input logic or_e, input logic ovf_e);
        chk({tag, ".O"}, 32'(O), 32'(o_e));
        chk({tag, ".COUNT"}, 32'(COUNT), 32'(c_e));
        chk({tag, ".IR"}, 32'(IR), 32'(ir_e));
        chk({tag, ".OR"}, 32'(OR), 32'(or_e));
        chk({tag, ".OVF"}, 32'(OVF), 32'(ovf_e));
    endtask

    initial begin
        logic [7:0] b;
        CLR_N  = 1'b0;
        I      = 8'h00;
        WR     = 1'b0;
        RD     = 1'b0;
        OENB_N = 1'b0;
        #1;
        chk_state("reset_init", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        CLR_N = 1'b1;

        // fill with 11..44
        WR = 1'b1; I = 8'h11; step();
        chk_state("fill1", 8'h11, 3'd1, 1'b1, 1'b1, 1'b0);
        I = 8'h22; step();
        I = 8'h33; step();
        chk("fill3.COUNT", 32'(COUNT), 32'd3);
        I = 8'h44; step();
        chk_state("fill4", 8'h11, 3'd4, 1'b0, 1'b1, 1'b0);

        // overflow, no read
        I = 8'hAA; step();
        chk_state("ovf_nord", 8'h11, 3'd4, 1'b0, 1'b1, 1'b1);
        WR = 1'b0;

        // drain
        RD = 1'b1; step();
        chk_state("drain1", 8'h22, 3'd3, 1'b1, 1'b1, 1'b1);
        step();
        chk("drain2.O", 32'(O), 32'h33);
        step();
        chk("drain3.O", 32'(O), 32'h44);
        step();
        chk("drain4.COUNT", 32'(COUNT), 32'd0);
        chk("drain4.OR", 32'(OR), 32'd0);
        step();
        chk_state("rd_empty", O, 3'd0, 1'b1, 1'b0, 1'b1);
        RD = 1'b0;

        // mid-cycle async reset with COUNT=3
        WR = 1'b1;
        I = 8'h01; step();
        I = 8'h02; step();
        I = 8'h03; step();
        WR = 1'b0;
        chk("pre_rst.COUNT", 32'(COUNT), 32'd3);
        #2 CLR_N = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        CLR_N = 1'b1;

        // fill, then overflow with simultaneous read
        WR = 1'b1;
        I = 8'hA1; step();
        I = 8'hA2; step();
        I = 8'hA3; step();
        I = 8'hA4; step();
        chk("full2.COUNT", 32'(COUNT), 32'd4);
        I = 8'hAA; RD = 1'b1; step();
        chk_state("ovf_rd", 8'hA2, 3'd3, 1'b1, 1'b1, 1'b1);
        WR = 1'b0;
        step();
        chk("ovf_drain1.O", 32'(O), 32'hA3);
        step();
        chk("ovf_drain2.O", 32'(O), 32'hA4);
        step();
        chk_state("ovf_empty", O, 3'd0, 1'b1, 1'b0, 1'b1);
        RD = 1'b0;

        CLR_N = 1'b0;
        #2;
        chk("ovf_clr.OVF", 32'(OVF), 32'd0);
        @(negedge CLK);
        CLR_N = 1'b1;

        // empty with simultaneous WR/RD
        WR = 1'b1; RD = 1'b1; I = 8'h5C; step();
        chk_state("empty_wr_rd", 8'h5C, 3'd1, 1'b1, 1'b1, 1'b0);

        // streaming across pointer wraps
        for (int k = 0; k < 12; k++) begin
            b = 8'h60 + 8'(k);
            I = b;
            step();
            chk($sformatf("stream%0d.O", k), 32'(O), 32'(b));
            chk($sformatf("stream%0d.COUNT", k), 32'(COUNT), 32'd1);
        end
        WR = 1'b0;
        step();
        chk_state("stream_end", O, 3'd0, 1'b1, 1'b0, 1'b0);
        RD = 1'b0;

        // output enable behaviour
        WR = 1'b1; I = 8'h3E; step();
        WR = 1'b0;
        OENB_N = 1'b1;
        #1;
`ifdef OCTAL_BUS_FIFO_TRISTATE_EN
        n_assert++;
        assert (O === 8'hzz)
        else begin
            n_fail++;
            $error("FAIL oe_off.O: observed %0h expected zz", O);
        end
`else
        chk("oe_off.O", 32'(O), 32'h3E);
`endif
        OENB_N = 1'b0;
        #1;
        chk("oe_on.O", 32'(O), 32'h3E);
        chk("oe.COUNT", 32'(COUNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
